// File: rtl/seq_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_serializer_pkg
// Description : Shared FSM state encodings for the serializer and the
//               downstream sequence-detector blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_serializer_pkg;

  // S_IDLE : shift register empty, nothing on the serial line
  // S_SHIFT: a word occupies the shift register (possibly awaiting its MSB)
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } seq_state_t;

endpackage : seq_serializer_pkg
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : seq_serializer
// Description : Parallel-to-serial converter feeding a bit-serial sequence
//               detector. MSB first, one bit per unstalled cycle, with a
//               one-entry holding buffer so consecutive words stream without
//               a gap. o_seq is forced low whenever no data bit is present.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic              i_stall,
  output logic              o_seq,
  output logic              o_seq_vld,
  output logic              o_last,
  output logic              o_busy
);

  localparam int                 c_CNT_W    = $clog2(DATA_W);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  // Registered state
  seq_state_t         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  r_hold;
  logic               r_hold_full;
  logic               r_seq;
  logic               r_seq_vld;
  logic               r_last;

  // Next-state values
  seq_state_t         w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic [DATA_W-1:0]  w_hold_nxt;
  logic               w_hold_full_nxt;
  logic               w_seq_nxt;
  logic               w_seq_vld_nxt;
  logic               w_last_nxt;

  logic               w_accept;
  logic               w_last_bit;

  // Ready only depends on buffer occupancy, never on i_vld.
  assign o_rdy      = !r_hold_full;
  assign w_accept   = i_vld && !r_hold_full;
  // The LSB is currently on the line; the next unstalled edge ends the word.
  assign w_last_bit = r_seq_vld && (r_cnt == c_CNT_LAST);

  assign o_seq      = r_seq;
  assign o_seq_vld  = r_seq_vld;
  assign o_last     = r_last;
  assign o_busy     = (r_state == S_SHIFT) || r_hold_full;

  // Next-state and serial output decode; every target defaults to "hold".
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_seq_nxt       = r_seq;
    w_seq_vld_nxt   = r_seq_vld;
    w_last_nxt      = r_last;

    case (r_state)
      S_IDLE: begin
        // Direct load is allowed even while stalled; the MSB then waits in
        // S_SHIFT until the stall drops.
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = i_data;
          w_cnt_nxt   = '0;
          if (!i_stall) begin
            w_seq_nxt     = i_data[DATA_W-1];
            w_seq_vld_nxt = 1'b1;
            w_last_nxt    = 1'b0;
          end
        end
      end

      S_SHIFT: begin
        if (i_stall) begin
          // Serial side frozen; the holding buffer may still fill.
          if (w_accept) begin
            w_hold_nxt      = i_data;
            w_hold_full_nxt = 1'b1;
          end
        end else if (!r_seq_vld) begin
          // Word was loaded during a stall: present its MSB now.
          w_seq_nxt     = r_shift[DATA_W-1];
          w_seq_vld_nxt = 1'b1;
          w_last_nxt    = 1'b0;
          if (w_accept) begin
            w_hold_nxt      = i_data;
            w_hold_full_nxt = 1'b1;
          end
        end else if (w_last_bit) begin
          // Word boundary: chain the next word in with no idle cycle.
          if (r_hold_full) begin
            w_shift_nxt     = r_hold;
            w_cnt_nxt       = '0;
            w_seq_nxt       = r_hold[DATA_W-1];
            w_seq_vld_nxt   = 1'b1;
            w_last_nxt      = 1'b0;
            w_hold_full_nxt = 1'b0;
          end else if (w_accept) begin
            w_shift_nxt   = i_data;
            w_cnt_nxt     = '0;
            w_seq_nxt     = i_data[DATA_W-1];
            w_seq_vld_nxt = 1'b1;
            w_last_nxt    = 1'b0;
          end else begin
            w_state_nxt   = S_IDLE;
            w_shift_nxt   = '0;
            w_cnt_nxt     = '0;
            w_seq_nxt     = 1'b0;
            w_seq_vld_nxt = 1'b0;
            w_last_nxt    = 1'b0;
          end
        end else begin
          // Mid-word: advance one bit; the bit on the line is always
          // r_shift[MSB], so the next one is the bit below it.
          w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
          w_seq_nxt   = r_shift[DATA_W-2];
          w_last_nxt  = ((r_cnt + c_CNT_ONE) == c_CNT_LAST);
          if (w_accept) begin
            w_hold_nxt      = i_data;
            w_hold_full_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset discards both the in-flight and buffered words.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_seq       <= 1'b0;
      r_seq_vld   <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_seq       <= w_seq_nxt;
      r_seq_vld   <= w_seq_vld_nxt;
      r_last      <= w_last_nxt;
    end
  end

endmodule : seq_serializer
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_serializer
// Description : Self-checking bench for seq_serializer. A queue model holds
//               the bit stream every accepted word must produce; a compare
//               process checks the serial outputs against it every cycle.
//               Directed scenarios add hand-computed cycle-exact checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_serializer;

  localparam int DATA_W = 8;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [DATA_W-1:0] i_data;
  logic              i_vld;
  logic              i_stall;
  logic              o_rdy;
  logic              o_seq;
  logic              o_seq_vld;
  logic              o_last;
  logic              o_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model: expected bit stream (MSB first) and its last-bit flags
  bit   exp_q[$];
  bit   exp_last_q[$];
  logic m_rdy        = 1'b0;
  logic m_prev_stall = 1'b0;
  logic m_held_bit   = 1'b0;
  logic m_held_last  = 1'b0;

  // Per-cycle capture for directed scenarios
  logic sa[0:40];
  logic va[0:40];
  logic la[0:40];
  logic ba[0:40];
  logic ra[0:40];

  always #5 i_clk = ~i_clk;

  seq_serializer #(.DATA_W(DATA_W)) u_dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_vld     (i_vld),
    .o_rdy     (o_rdy),
    .i_stall   (i_stall),
    .o_seq     (o_seq),
    .o_seq_vld (o_seq_vld),
    .o_last    (o_last),
    .o_busy    (o_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rec(input int k);
    sa[k] = o_seq;
    va[k] = o_seq_vld;
    la[k] = o_last;
    ba[k] = o_busy;
    ra[k] = o_rdy;
  endtask

  // Model update: an accepted word contributes DATA_W bits, MSB first.
  always @(posedge i_clk) begin
    m_prev_stall <= i_stall;
    if (i_rst) begin
      exp_q.delete();
      exp_last_q.delete();
    end else if (i_vld && m_rdy) begin
      for (int b = DATA_W - 1; b >= 0; b--) begin
        exp_q.push_back(i_data[b]);
        exp_last_q.push_back(b == 0);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge i_clk) begin
    m_rdy = o_rdy;
    if (!o_seq_vld) begin
      check("idle_low_seq", o_seq, 1'b0);
      check("idle_low_last", o_last, 1'b0);
    end else if (m_prev_stall) begin
      check("stall_hold_seq", o_seq, m_held_bit);
      check("stall_hold_last", o_last, m_held_last);
    end else if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_bit: got o_seq_vld=1, expected no pending bits (t=%0t)", $time);
    end else begin
      m_held_bit  = exp_q.pop_front();
      m_held_last = exp_last_q.pop_front();
      check("stream_bit", o_seq, m_held_bit);
      check("stream_last", o_last, m_held_last);
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  bits_a5;
    logic [10:0] seq_96;
    logic [8:0]  det;
    logic [7:0]  words[0:2];
    logic        acc;
    int          nacc, vcount, first, lastk;

    // ---------------- reset, with a word presented during reset ------------
    i_rst   = 1'b1;
    i_vld   = 1'b1;
    i_data  = 8'hFF;
    i_stall = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_rdy", o_rdy, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_vld", o_seq_vld, 1'b0);
    check("rst_seq", o_seq, 1'b0);
    check("rst_last", o_last, 1'b0);
    i_rst = 1'b0;
    i_vld = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      check("post_rst_vld", o_seq_vld, 1'b0);
      check("post_rst_busy", o_busy, 1'b0);
    end

    // ---------------- single word A5 ----------------------------------------
    i_data = 8'hA5;
    i_vld  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge i_clk);
      i_vld = 1'b0;
      rec(k);
    end
    bits_a5 = 8'b10100101;
    for (int k = 1; k <= 8; k++) begin
      check("a5_bit", sa[k], bits_a5[8-k]);
      check("a5_vld", va[k], 1'b1);
      check("a5_last", la[k], (k == 8));
    end
    check("a5_end_vld", va[9], 1'b0);
    check("a5_end_busy", ba[9], 1'b0);
    det = '0;
    for (int k = 3; k <= 8; k++)
      if (sa[k-2] == 1'b1 && sa[k-1] == 1'b0 && sa[k] == 1'b1) det[k] = 1'b1;
    check("a5_detector_hits", det, 9'h108);
    check("a5_drained", exp_q.size(), 0);

    // ---------------- back-to-back FF, 00, 5A -------------------------------
    words[0] = 8'hFF;
    words[1] = 8'h00;
    words[2] = 8'h5A;
    nacc   = 0;
    i_data = words[0];
    i_vld  = 1'b1;
    acc    = o_rdy;
    for (int k = 1; k <= 30; k++) begin
      @(negedge i_clk);
      if (acc) begin
        nacc++;
        if (nacc < 3) i_data = words[nacc];
        else          i_vld  = 1'b0;
      end
      rec(k);
      acc = i_vld && o_rdy;
    end
    vcount = 0;
    first  = 0;
    lastk  = 0;
    for (int k = 1; k <= 30; k++) begin
      if (va[k]) begin
        vcount++;
        if (first == 0) first = k;
        lastk = k;
      end
    end
    check("b2b_accepted", nacc, 3);
    check("b2b_valid_bits", vcount, 24);
    check("b2b_first", first, 1);
    check("b2b_contiguous", lastk - first + 1, 24);
    check("b2b_rdy_c1", ra[1], 1'b1);
    check("b2b_rdy_c2", ra[2], 1'b0);
    check("b2b_rdy_c8", ra[8], 1'b0);
    check("b2b_rdy_c9", ra[9], 1'b1);
    check("b2b_rdy_c10", ra[10], 1'b0);
    check("b2b_rdy_c17", ra[17], 1'b1);
    check("b2b_last_c8", la[8], 1'b1);
    check("b2b_seq_c9", sa[9], 1'b0);
    check("b2b_busy_c25", ba[25], 1'b0);
    check("b2b_drained", exp_q.size(), 0);

    // ---------------- 96 with a 3-cycle stall after bit 2 -------------------
    i_data = 8'h96;
    i_vld  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge i_clk);
      i_vld = 1'b0;
      rec(k);
      i_stall = (k >= 3 && k <= 5);
    end
    seq_96 = 11'b10000010110;
    for (int k = 1; k <= 11; k++) begin
      check("stall_seq", sa[k], seq_96[11-k]);
      check("stall_vld", va[k], 1'b1);
      check("stall_last", la[k], (k == 11));
    end
    check("stall_end_vld", va[12], 1'b0);
    check("stall_drained", exp_q.size(), 0);

    // ---------------- load during idle stall, buffer fills while stalled ----
    i_stall = 1'b1;
    i_data  = 8'h81;
    i_vld   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      rec(k);
      i_vld = (k == 1);
      if (k == 1) i_data = 8'h42;
      if (k >= 2) i_stall = 1'b0;
    end
    check("istall_c1_vld", va[1], 1'b0);
    check("istall_c1_busy", ba[1], 1'b1);
    check("istall_c2_vld", va[2], 1'b0);
    check("istall_c2_rdy", ra[2], 1'b0);
    check("istall_c3_vld", va[3], 1'b1);
    check("istall_c3_seq", sa[3], 1'b1);
    check("istall_c10_last", la[10], 1'b1);
    check("istall_c10_seq", sa[10], 1'b1);
    check("istall_c11_vld", va[11], 1'b1);
    check("istall_c11_seq", sa[11], 1'b0);
    check("istall_c18_last", la[18], 1'b1);
    check("istall_c19_vld", va[19], 1'b0);
    check("istall_drained", exp_q.size(), 0);

    // ---------------- reset mid-word with a buffered word -------------------
    i_data = 8'hC3;
    i_vld  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      rec(k);
      if (k == 1) i_data = 8'h3C;
      if (k == 2) i_vld  = 1'b0;
      i_rst = (k == 5);
    end
    check("rstmid_buffered", ra[2], 1'b0);
    check("rstmid_c5_vld", va[5], 1'b1);
    check("rstmid_c5_seq", sa[5], 1'b0);
    check("rstmid_c6_vld", va[6], 1'b0);
    check("rstmid_c6_rdy", ra[6], 1'b1);
    check("rstmid_c6_busy", ba[6], 1'b0);
    vcount = 0;
    for (int k = 6; k <= 20; k++) if (va[k]) vcount++;
    check("rstmid_no_bits_after", vcount, 0);
    check("rstmid_flushed", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_seq_serializer
`default_nettype wire
